// File: rtl/hi_lo_unit.sv
// ---------------------------------------------------------------------------
// hi_lo_unit
//
// Multi-cycle multiply/divide unit that owns the architectural HI and LO
// registers. Executes MTHI, MTLO, MULT, MULTU, DIV and DIVU. Iterative ops
// take 32 cycles, and busy is held high meanwhile so the pipeline can stall.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset_n   in   1   asynchronous active-low reset
//   valid     in   1   execute-stage instruction is live
//   funct     in   6   R-type funct field
//   HI_write  in   2   decoder strobe, asserted only when 2'b11
//   LO_write  in   2   decoder strobe, asserted only when 2'b11
//   rs_data   in  32   multiplicand / dividend / MTHI-MTLO source
//   rt_data   in  32   multiplier / divisor
//   busy      out  1   registered, high while an iterative op is in flight
//   hi        out 32   HI register
//   lo        out 32   LO register
//
// Build option:
//   HILO_FAST_MULT_EN  when defined, MULT/MULTU finish in a single cycle using
//                      a full 64-bit multiplier; DIV/DIVU remain iterative.
// ---------------------------------------------------------------------------
module hi_lo_unit #(
    parameter int ITER_BITS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [5:0]  funct,
    input  logic [1:0]  HI_write,
    input  logic [1:0]  LO_write,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    logic [1:0]           state_q,   state_d;
    logic [ITER_BITS-1:0] cnt_q,     cnt_d;
    logic                 busy_q,    busy_d;
    logic [31:0]          hi_q,      hi_d;
    logic [31:0]          lo_q,      lo_d;
    logic [63:0]          mcand_q,   mcand_d;
    logic [31:0]          opB_q,     opB_d;
    logic [63:0]          prod_q,    prod_d;
    logic [31:0]          rem_q,     rem_d;
    logic [31:0]          quot_q,    quot_d;
    logic                 resNeg_q,  resNeg_d;
    logic                 remNeg_q,  remNeg_d;
    logic                 divZero_q, divZero_d;

    logic        request;
    logic        signedOp;
    logic [31:0] opAMag;
    logic [31:0] opBMag;
    logic        lastIter;
    logic [63:0] mulSum;
    logic [32:0] partRem;
    logic        qBit;
    logic [31:0] remSub;
    logic [31:0] divRem;
    logic [31:0] quotNext;

    assign request  = valid && ((HI_write == 2'b11) || (LO_write == 2'b11)) && (state_q == IDLE);

    // Even funct codes (0x18, 0x1a) are the signed variants.
    assign signedOp = ~funct[0];
    assign opAMag   = (signedOp && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign opBMag   = (signedOp && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

    assign lastIter = (cnt_q == {ITER_BITS{1'b1}});

    // Shift-add: the multiplicand is pre-shifted each cycle, the multiplier
    // is consumed LSB first.
    assign mulSum   = prod_q + (opB_q[0] ? mcand_q : 64'd0);

    // Restoring division: bring down the next dividend bit into a 33-bit
    // partial remainder. Since the remainder is always below the divisor,
    // the difference fits in 32 bits once the subtraction is known to hold.
    assign partRem  = {rem_q, quot_q[31]};
    assign qBit     = (partRem >= {1'b0, opB_q});
    assign remSub   = partRem[31:0] - opB_q;
    assign divRem   = qBit ? remSub : partRem[31:0];
    assign quotNext = {quot_q[30:0], qBit};

`ifdef HILO_FAST_MULT_EN
    logic [63:0] fastMag;
    logic [63:0] fastProd;
    assign fastMag  = {32'd0, opAMag} * {32'd0, opBMag};
    assign fastProd = (signedOp && (rs_data[31] ^ rt_data[31])) ? (~fastMag + 64'd1) : fastMag;
`endif

    // Next-state logic: IDLE dispatches requests, MUL and DIV each retire
    // one bit per cycle and write HI/LO on the 32nd iteration.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        opB_d     = opB_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        resNeg_d  = resNeg_q;
        remNeg_d  = remNeg_q;
        divZero_d = divZero_q;

        case (state_q)
            IDLE: begin
                if (request) begin
                    case (funct)
                        F_MTHI: hi_d = rs_data;
                        F_MTLO: lo_d = rs_data;
                        F_MULT, F_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                            {hi_d, lo_d} = fastProd;
`else
                            mcand_d   = {32'd0, opAMag};
                            opB_d     = opBMag;
                            prod_d    = 64'd0;
                            resNeg_d  = signedOp && (rs_data[31] ^ rt_data[31]);
                            remNeg_d  = 1'b0;
                            divZero_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = MUL;
                            busy_d    = 1'b1;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            quot_d    = opAMag;
                            opB_d     = opBMag;
                            rem_d     = 32'd0;
                            resNeg_d  = signedOp && (rs_data[31] ^ rt_data[31]);
                            remNeg_d  = signedOp && rs_data[31];
                            divZero_d = (rt_data == 32'd0);
                            cnt_d     = '0;
                            state_d   = DIV;
                            busy_d    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            MUL: begin
                prod_d  = mulSum;
                mcand_d = {mcand_q[62:0], 1'b0};
                opB_d   = {1'b0, opB_q[31:1]};
                cnt_d   = cnt_q + 1'b1;
                if (lastIter) begin
                    {hi_d, lo_d} = resNeg_q ? (~mulSum + 64'd1) : mulSum;
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                end
            end

            DIV: begin
                rem_d  = divRem;
                quot_d = quotNext;
                cnt_d  = cnt_q + 1'b1;
                if (lastIter) begin
                    // With a zero divisor every trial subtraction succeeds,
                    // so the remainder already reproduces rs; only LO needs
                    // forcing to all ones regardless of sign.
                    if (divZero_q)
                        lo_d = 32'hFFFF_FFFF;
                    else
                        lo_d = resNeg_q ? (~quotNext + 32'd1) : quotNext;
                    hi_d    = remNeg_q ? (~divRem + 32'd1) : divRem;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            mcand_q   <= 64'd0;
            opB_q     <= 32'd0;
            prod_q    <= 64'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            resNeg_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            opB_q     <= opB_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            resNeg_q  <= resNeg_d;
            remNeg_q  <= remNeg_d;
            divZero_q <= divZero_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// ---------------------------------------------------------------------------
// tb_hi_lo_unit
//
// Self-checking bench for hi_lo_unit: directed cases followed by randomized
// instructions, all compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_hi_lo_unit;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [5:0]  funct;
    logic [1:0]  HI_write;
    logic [1:0]  LO_write;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] expHi;
    logic [31:0] expLo;
    bit          fastMul;

    hi_lo_unit #(.ITER_BITS(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (valid),
        .funct    (funct),
        .HI_write (HI_write),
        .LO_write (LO_write),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: architectural {hi,lo} after an accepted instruction.
    function automatic logic [63:0] refResult(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] oldHi,
                                               input logic [31:0] oldLo);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h11: return {a, oldLo};
            6'h13: return {oldHi, a};
            6'h18: begin
                sp = sa * sb;
                return sp[63:0];
            end
            6'h19: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            6'h1a: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            6'h1b: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {oldHi, oldLo};
        endcase
    endfunction

    // Issue one instruction, optionally poke a request while busy, wait for
    // completion and compare against the model.
    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [1:0] hw,
                                 input logic [1:0] lw, input logic [31:0] a, input logic [31:0] b,
                                 input bit spurious);
        logic        req;
        logic        iter;
        logic [63:0] res;
        int          cycles;
        req  = v && ((hw == 2'b11) || (lw == 2'b11));
        iter = req && (((f == 6'h18 || f == 6'h19) && !fastMul) || f == 6'h1a || f == 6'h1b);
        res  = req ? refResult(f, a, b, expHi, expLo) : {expHi, expLo};

        @(negedge clk);
        valid = v; funct = f; HI_write = hw; LO_write = lw; rs_data = a; rt_data = b;
        @(posedge clk);
        #1;
        valid = 1'b0; HI_write = 2'b00; LO_write = 2'b00;

        if (iter) begin
            checkOutput("busyRise", busy, 1);
            checkOutput("hiHold", hi, expHi);
            checkOutput("loHold", lo, expLo);
            cycles = 0;
            while (busy && cycles < 40) begin
                if (spurious && cycles == 3) begin
                    @(negedge clk);
                    valid = 1'b1; funct = 6'h11; HI_write = 2'b11; LO_write = 2'b11;
                    rs_data = $urandom;
                end
                @(posedge clk);
                #1;
                valid = 1'b0; HI_write = 2'b00; LO_write = 2'b00;
                cycles++;
            end
            checkOutput("latency", cycles, 32);
        end else begin
            checkOutput("busyLow", busy, 0);
        end
        {expHi, expLo} = res;
        checkOutput("hi", hi, expHi);
        checkOutput("lo", lo, expLo);
    endtask

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cycles;
        logic [5:0] fset [8];
        fastMul = 1'b0;
`ifdef HILO_FAST_MULT_EN
        fastMul = 1'b1;
`endif
        fset = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h20};
        expHi = 32'd0; expLo = 32'd0;
        valid = 1'b0; funct = 6'd0; HI_write = 2'b00; LO_write = 2'b00;
        rs_data = 32'd0; rt_data = 32'd0;

        // Power-on reset.
        reset_n = 1'b0;
        #12;
        checkOutput("rstHi", hi, 0);
        checkOutput("rstLo", lo, 0);
        checkOutput("rstBusy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases.
        applyStimulus(1, 6'h11, 2'b11, 2'b00, 32'h1234_5678, 32'd0, 0);
        applyStimulus(1, 6'h13, 2'b00, 2'b11, 32'hCAFE_F00D, 32'd0, 0);
        checkOutput("mthiConst", hi, 32'h1234_5678);
        checkOutput("mtloConst", lo, 32'hCAFE_F00D);
        applyStimulus(1, 6'h18, 2'b11, 2'b11, 32'hFFFF_FFFE, 32'd3, 0);
        checkOutput("multConst", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        applyStimulus(1, 6'h19, 2'b11, 2'b11, 32'hFFFF_FFFE, 32'd3, 1);
        checkOutput("multuConst", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        applyStimulus(1, 6'h1a, 2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        checkOutput("divConst", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(1, 6'h1a, 2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checkOutput("divOvfConst", {hi, lo}, 64'h0000_0000_8000_0000);
        applyStimulus(1, 6'h1a, 2'b11, 2'b11, 32'hFFFF_FFF0, 32'd0, 0);
        checkOutput("divZeroConst", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
        applyStimulus(1, 6'h1b, 2'b11, 2'b11, 32'd7, 32'd0, 0);
        checkOutput("divuZeroConst", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        applyStimulus(1, 6'h19, 2'b11, 2'b11, 32'h0001_0000, 32'h0001_0000, 0);
        checkOutput("fastMulConst", {hi, lo}, 64'h0000_0001_0000_0000);

        // Reset in the middle of a DIVU, with an MTHI poked while busy.
        @(negedge clk);
        valid = 1'b1; funct = 6'h1b; HI_write = 2'b11; LO_write = 2'b11;
        rs_data = 32'd100; rt_data = 32'd7;
        @(posedge clk);
        #1;
        valid = 1'b0; HI_write = 2'b00; LO_write = 2'b00;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                @(negedge clk);
                valid = 1'b1; funct = 6'h11; HI_write = 2'b11; rs_data = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            #1;
            valid = 1'b0; HI_write = 2'b00;
            if (c == 5) checkOutput("mthiIgnored", hi, expHi);
        end
        checkOutput("midBusy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncRstHi", hi, 0);
        checkOutput("asyncRstLo", lo, 0);
        checkOutput("asyncRstBusy", busy, 0);
        expHi = 32'd0; expLo = 32'd0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        applyStimulus(1, 6'h1b, 2'b11, 2'b11, 32'd100, 32'd7, 0);
        checkOutput("divuConst", {hi, lo}, 64'h0000_0002_0000_000E);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic       v;
            logic [1:0] hw, lw;
            v = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) != 0) begin
                hw = 2'b11; lw = 2'b11;
            end else begin
                hw = 2'($urandom_range(0, 3)); lw = 2'($urandom_range(0, 3));
            end
            applyStimulus(v, fset[$urandom_range(0, 7)], hw, lw, pickOperand(), pickOperand(),
                          bit'($urandom_range(0, 1)));
        end

        // Idle for a while with no requests: nothing may change.
        cycles = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("idleHi", hi, expHi);
        checkOutput("idleLo", lo, expLo);
        checkOutput("idleBusy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hi_lo_unit.md
# hi_lo_unit

Multi-cycle multiply/divide unit holding the architectural HI and LO registers. It sits in the execute stage directly downstream of the instruction decoder and consumes its `HI_write`/`LO_write` strobes plus `funct`. It executes MTHI, MTLO, MULT, MULTU, DIV and DIVU. It exposes `hi`/`lo` to the MFHI/MFLO writeback path and raises `busy` so the pipeline can stall.

## Interface
Parameters:
- `ITER_BITS`, 5: width of the iteration counter; 2^ITER_BITS must equal 32.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid`  in  1  execute-stage instruction is live (not flushed, not bubble).
- `funct`  in  6  R-type funct field.
- `HI_write`  in  2  decoder strobe; only 2'b11 counts as asserted.
- `LO_write`  in  2  decoder strobe; only 2'b11 counts as asserted.
- `rs_data`  in  32  rs operand (multiplicand, dividend, MTHI/MTLO source).
- `rt_data`  in  32  rt operand (multiplier, divisor).
- `busy`  out  1  registered; high while an iterative op is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Request = `valid` & (`HI_write`==11 | `LO_write`==11) & state IDLE. Requests in MUL or DIV are ignored. The pipeline must hold the instruction while `busy`.
- States: IDLE, MUL, DIV.
- In IDLE with a request:
  - funct 0x11 (MTHI): `hi`<=`rs_data`. `lo` unchanged. Stay in IDLE.
  - funct 0x13 (MTLO): `lo`<=`rs_data`. `hi` unchanged. Stay in IDLE.
  - funct 0x18/0x19 (MULT/MULTU): latch operands, go to MUL.
  - funct 0x1a/0x1b (DIV/DIVU): latch operands, go to DIV.
  - Any other funct: no effect.
- Operand latch:
  - Signed ops store magnitudes plus a result-sign flag (mult: sign(rs)^sign(rt)) and a remainder-sign flag (div: sign(rs)).
  - Unsigned ops store the raw operands.
  - Counter cleared to 0.
- MUL: shift-add, one multiplier bit per cycle into a 64-bit accumulator. Unsigned 32x32 gives a 64-bit result. The final product is negated if the result-sign flag is set. Then {`hi`,`lo`}<=product.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder. At the end:
  - `lo`<=quotient, negated if sign(rs)^sign(rt) for DIV.
  - `hi`<=remainder, negated if the remainder-sign flag is set for DIV.
- Divide by zero (`rt_data`==0, either signedness): `lo`=32'hFFFFFFFF, `hi`=original `rs_data`. Still takes the full 32 iterations.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=32'h80000000, `hi`=0.
- After writing the result, state returns to IDLE.
- `hi`/`lo` are direct register outputs. During `busy` they hold the pre-operation values.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `hi`=0, `lo`=0, `busy`=0, state IDLE, counter 0.
  - Any in-flight op is discarded.
- MTHI/MTLO: single cycle. Value is visible after the accepting edge. `busy` never rises.
- MULT/MULTU/DIV/DIVU:
  - Accepting edge E0: `busy` goes high after E0.
  - Iterations run on edges E1..E32.
  - Results are written and `busy` drops at E32. Latency is 32 cycles.
- A new request is accepted on the first edge where `busy`=0, earliest E33.
- If reset is released mid-cycle, the block starts in IDLE on the next edge. No partial result is ever written.

## Configuration
- `HILO_FAST_MULT_EN` defined:
  - MULT/MULTU compute with a single-cycle 64-bit multiplier.
  - {`hi`,`lo`} is written at the accepting edge. `busy` stays 0. MUL state unused.
  - DIV/DIVU unchanged.
- Undefined: MULT/MULTU use the 32-cycle iterative path above.

## Test plan
- Reset: hold `reset_n` low mid-run -> `hi`=0, `lo`=0, `busy`=0 immediately, without waiting for a clock edge.
- MTHI `rs_data`=0x12345678, then MTLO 0xCAFEF00D -> `hi`=0x12345678, `lo`=0xCAFEF00D, one cycle each, `busy` never high.
- MULT rs=0xFFFFFFFE, rt=3 -> after 32 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9, rt=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU rs=7, rt=0 -> `lo`=0xFFFFFFFF, `hi`=7.
- Start DIVU 100/7, pulse MTHI at cycle 5, assert `reset_n` low at cycle 10 -> MTHI ignored, all outputs 0 after reset. A fresh DIVU 100/7 then gives `lo`=14, `hi`=2 at E32.
- With `HILO_FAST_MULT_EN`: MULTU 0x10000 x 0x10000 -> `hi`=1, `lo`=0 after one edge, `busy` stays 0.
